// File: rtl/dma_fmi_loader.sv
// Input-side DMA: fetches one Tix x Tiy x Tif feature-map tile row by row
// into the FMI RAM, zero-filling rows that lie below the feature map.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              one-cycle launch pulse, honoured only when idle
//   base_addr          word address of tile element (f=0,y=0,x=0)
//   row_stride         word distance between consecutive rows
//   ch_stride          word distance between consecutive feature planes
//   fm_h, tile_y0      feature-map height, first tile row index
//   busy, done         load in progress / one-cycle completion pulse
//   mem_req/ready      burst read request handshake
//   mem_addr, mem_len  burst start address and length (Tix)
//   mem_rvalid/rdata   read data beats
//   ram_we/addr/wdata  registered FMI RAM write port

package dma_pkg;
  localparam int Tix = 4;
  localparam int Tiy = 4;
  localparam int Tif = 8;
  localparam int FMI_N_ELEM = Tix * Tiy * Tif;
  localparam int FMI_ADDR_W = $clog2(FMI_N_ELEM);
endpackage

module dma_fmi_loader
  import dma_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int EXT_ADDR_W = 32,
  parameter int DIM_W      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [EXT_ADDR_W-1:0] base_addr,
  input  logic [EXT_ADDR_W-1:0] row_stride,
  input  logic [EXT_ADDR_W-1:0] ch_stride,
  input  logic [DIM_W-1:0]      fm_h,
  input  logic [DIM_W-1:0]      tile_y0,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req,
  input  logic                  mem_ready,
  output logic [EXT_ADDR_W-1:0] mem_addr,
  output logic [7:0]            mem_len,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  ram_we,
  output logic [FMI_ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0]     ram_wdata
);

  localparam int XW = (Tix > 1) ? $clog2(Tix) : 1;
  localparam int YW = (Tiy > 1) ? $clog2(Tiy) : 1;
  localparam int FW = (Tif > 1) ? $clog2(Tif) : 1;
  localparam int EW = DIM_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_REQ,
    S_DATA,
    S_PAD,
    S_NEXT,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [EXT_ADDR_W-1:0] row_addr;
  logic [EXT_ADDR_W-1:0] plane_addr;
  logic [EXT_ADDR_W-1:0] rs_q;
  logic [EXT_ADDR_W-1:0] cs_q;
  logic [DIM_W-1:0]      fmh_q;
  logic [DIM_W-1:0]      y0_q;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [FW-1:0]         f;
  logic [FMI_ADDR_W-1:0] wr_ptr;

  logic x_last;
  logic y_last;
  logic f_last;
  logic row_in;
  logic beat;
  logic pad;

  assign x_last = (x == XW'(Tix - 1));
  assign y_last = (y == YW'(Tiy - 1));
  assign f_last = (f == FW'(Tif - 1));

  // One extra bit so tile_y0 + y cannot wrap past fm_h.
  assign row_in = ({1'b0, y0_q} + EW'(y)) < {1'b0, fmh_q};

  assign beat = (state == S_DATA) && mem_rvalid;
  assign pad  = (state == S_PAD);

  assign mem_addr = row_addr;
  assign mem_len  = 8'(Tix);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    mem_req = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_n = S_CHK;
      end
      S_CHK: begin
        busy    = 1'b1;
        state_n = row_in ? S_REQ : S_PAD;
      end
      S_REQ: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) state_n = S_DATA;
      end
      S_DATA: begin
        busy = 1'b1;
        if (beat && x_last) state_n = S_NEXT;
      end
      S_PAD: begin
        busy = 1'b1;
        if (x_last) state_n = S_NEXT;
      end
      S_NEXT: begin
        busy    = 1'b1;
        state_n = (f_last && y_last) ? S_DONE : S_CHK;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_addr   <= '0;
      plane_addr <= '0;
      rs_q       <= '0;
      cs_q       <= '0;
      fmh_q      <= '0;
      y0_q       <= '0;
      x          <= '0;
      y          <= '0;
      f          <= '0;
      wr_ptr     <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      ram_we <= beat || pad;
      if (beat || pad) begin
        ram_addr  <= wr_ptr;
        ram_wdata <= pad ? '0 : mem_rdata;
        wr_ptr    <= wr_ptr + 1'b1;
        x         <= x_last ? '0 : x + 1'b1;
      end
      if (state == S_IDLE && start) begin
        row_addr   <= base_addr;
        plane_addr <= base_addr;
        rs_q       <= row_stride;
        cs_q       <= ch_stride;
        fmh_q      <= fm_h;
        y0_q       <= tile_y0;
        x          <= '0;
        y          <= '0;
        f          <= '0;
        wr_ptr     <= '0;
      end
      if (state == S_NEXT) begin
        if (y_last) begin
          // Plane boundary: rebase from the plane start, not the last row.
          y          <= '0;
          f          <= f + 1'b1;
          plane_addr <= plane_addr + cs_q;
          row_addr   <= plane_addr + cs_q;
        end else begin
          y        <= y + 1'b1;
          row_addr <= row_addr + rs_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_fmi_loader.sv
// Randomized self-checking bench for dma_fmi_loader: memory responder,
// RAM write monitor and a tile-level reference model.
module tb_dma_fmi_loader;
  import dma_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] row_stride;
  logic [31:0] ch_stride;
  logic [9:0]  fm_h;
  logic [9:0]  tile_y0;
  logic        busy;
  logic        done;
  logic        mem_req;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [7:0]  mem_len;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;
  logic        ram_we;
  logic [FMI_ADDR_W-1:0] ram_addr;
  logic [7:0]  ram_wdata;

  always #5 clk = ~clk;

  dma_fmi_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .row_stride(row_stride),
    .ch_stride(ch_stride), .fm_h(fm_h), .tile_y0(tile_y0),
    .busy(busy), .done(done),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  ram     [FMI_N_ELEM];
  logic [7:0]  exp_ram [FMI_N_ELEM];
  logic [31:0] req_q   [$];
  logic [31:0] exp_req [$];

  int wr_count, seq_err, done_cnt, done_bad, unstable;
  int ready_wait = 0;
  int gap_pct    = 0;
  bit stray      = 0;

  logic [31:0] cfg_base, cfg_rs, cfg_cs;
  logic [9:0]  cfg_fmh, cfg_y0;

  // RAM write / done monitor
  initial forever begin
    @(negedge clk);
    if (ram_we) begin
      if (int'(ram_addr) != wr_count) seq_err++;
      ram[ram_addr] = ram_wdata;
      wr_count++;
    end
    if (done) begin
      done_cnt++;
      if (wr_count != FMI_N_ELEM || busy) done_bad++;
    end
  end

  // External memory: data = low byte of the word address
  initial begin
    logic [31:0] baddr;
    logic [31:0] held;
    int beats;
    int wc;
    bit holding;
    beats = 0; wc = 0; holding = 0;
    baddr = 0; held = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    forever begin
      @(negedge clk);
      mem_ready  = 0;
      mem_rvalid = 0;
      if (rst) begin
        beats = 0; wc = 0; holding = 0;
      end else if (beats > 0) begin
        if ($urandom_range(99) >= gap_pct) begin
          mem_rvalid = 1;
          mem_rdata  = baddr[7:0];
          baddr++;
          beats--;
        end
      end else if (mem_req) begin
        if (holding && mem_addr !== held) unstable++;
        held = mem_addr;
        holding = 1;
        if (wc >= ready_wait) begin
          mem_ready = 1;
          req_q.push_back(mem_addr);
          baddr = mem_addr;
          beats = Tix;
          wc = 0;
          holding = 0;
        end else begin
          wc++;
        end
      end else if (stray) begin
        mem_rvalid = 1;
        mem_rdata  = 8'hAA;
        stray = 0;
      end
    end
  end

  task automatic build_model();
    exp_req.delete();
    for (int f = 0; f < Tif; f++)
      for (int y = 0; y < Tiy; y++) begin
        logic [31:0] ra;
        bit inb;
        ra  = cfg_base + f * cfg_cs + y * cfg_rs;
        inb = (int'(cfg_y0) + y) < int'(cfg_fmh);
        if (inb) exp_req.push_back(ra);
        for (int x = 0; x < Tix; x++)
          exp_ram[f*Tix*Tiy + y*Tix + x] = inb ? 8'(ra + x) : 8'h00;
      end
  endtask

  task automatic launch();
    wr_count = 0; seq_err = 0; done_cnt = 0;
    done_bad = 0; unstable = 0;
    req_q.delete();
    for (int i = 0; i < FMI_N_ELEM; i++) ram[i] = 8'hEE;
    build_model();
    @(negedge clk);
    base_addr  = cfg_base;
    row_stride = cfg_rs;
    ch_stride  = cfg_cs;
    fm_h       = cfg_fmh;
    tile_y0    = cfg_y0;
    start      = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done_cnt == 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == 0) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: done not seen, writes=%0d", wr_count);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; start = 0;
    base_addr = 0; row_stride = 0; ch_stride = 0;
    fm_h = 0; tile_y0 = 0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, done, mem_req, ram_we} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000",
               {busy, done, mem_req, ram_we});
    end
    n_tests++;
    if (mem_addr !== 32'h0 || ram_addr !== '0 || ram_wdata !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h raddr=%h wdata=%h want 0",
               mem_addr, ram_addr, ram_wdata);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_full();
    cfg_base = 32'h1000; cfg_rs = 16; cfg_cs = 256;
    cfg_fmh = 16; cfg_y0 = 0;
    ready_wait = 0; gap_pct = 0;
    launch();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL full_busy: got %b want 1", busy);
    end
    n_tests++;
    if (mem_len !== 8'd4) begin
      n_fail++; $display("FAIL full_len: got %0d want 4", mem_len);
    end
    wait_done();
    n_tests++;
    if (req_q.size() != 32) begin
      n_fail++; $display("FAIL full_nreq: got %0d want 32", req_q.size());
    end
    for (int i = 0; i < exp_req.size() && i < req_q.size(); i++) begin
      n_tests++;
      if (req_q[i] !== exp_req[i]) begin
        n_fail++;
        $display("FAIL full_req[%0d]: got %h want %h", i, req_q[i], exp_req[i]);
      end
    end
    for (int i = 0; i < FMI_N_ELEM; i++) begin
      n_tests++;
      if (ram[i] !== exp_ram[i]) begin
        n_fail++;
        $display("FAIL full_ram[%0d]: got %h want %h", i, ram[i], exp_ram[i]);
      end
    end
    n_tests++;
    if (ram[5] !== 8'h11 || req_q.size() < 5 || req_q[4] !== 32'h1100) begin
      n_fail++;
      $display("FAIL full_spot: ram5=%h want 11, req4 wrong or missing", ram[5]);
    end
    n_tests++;
    if (wr_count != 128 || done_cnt != 1 || done_bad != 0 || seq_err != 0) begin
      n_fail++;
      $display("FAIL full_cnt: wr=%0d done=%0d bad=%0d seq=%0d want 128 1 0 0",
               wr_count, done_cnt, done_bad, seq_err);
    end
  endtask

  task automatic test_pad();
    cfg_base = 32'h2000; cfg_rs = 16; cfg_cs = 256;
    cfg_fmh = 6; cfg_y0 = 4;
    ready_wait = 0; gap_pct = 0;
    launch();
    wait_done();
    n_tests++;
    if (req_q.size() != 16) begin
      n_fail++; $display("FAIL pad_nreq: got %0d want 16", req_q.size());
    end
    for (int i = 0; i < exp_req.size() && i < req_q.size(); i++) begin
      n_tests++;
      if (req_q[i] !== exp_req[i]) begin
        n_fail++;
        $display("FAIL pad_req[%0d]: got %h want %h", i, req_q[i], exp_req[i]);
      end
    end
    for (int i = 0; i < FMI_N_ELEM; i++) begin
      n_tests++;
      if (ram[i] !== exp_ram[i]) begin
        n_fail++;
        $display("FAIL pad_ram[%0d]: got %h want %h", i, ram[i], exp_ram[i]);
      end
    end
    for (int i = 8; i < 16; i++) begin
      n_tests++;
      if (ram[i] !== 8'h00) begin
        n_fail++; $display("FAIL pad_zero[%0d]: got %h want 00", i, ram[i]);
      end
    end
    n_tests++;
    if (wr_count != 128 || done_cnt != 1 || done_bad != 0 || seq_err != 0) begin
      n_fail++;
      $display("FAIL pad_cnt: wr=%0d done=%0d bad=%0d seq=%0d",
               wr_count, done_cnt, done_bad, seq_err);
    end
  endtask

  task automatic test_backpressure();
    cfg_base = 32'h1000; cfg_rs = 16; cfg_cs = 256;
    cfg_fmh = 16; cfg_y0 = 0;
    ready_wait = 3; gap_pct = 40;
    launch();
    wait_done();
    n_tests++;
    if (unstable != 0) begin
      n_fail++; $display("FAIL bp_stable: changes=%0d want 0", unstable);
    end
    n_tests++;
    if (req_q.size() != exp_req.size()) begin
      n_fail++;
      $display("FAIL bp_nreq: got %0d want %0d", req_q.size(), exp_req.size());
    end
    for (int i = 0; i < exp_req.size() && i < req_q.size(); i++) begin
      n_tests++;
      if (req_q[i] !== exp_req[i]) begin
        n_fail++;
        $display("FAIL bp_req[%0d]: got %h want %h", i, req_q[i], exp_req[i]);
      end
    end
    for (int i = 0; i < FMI_N_ELEM; i++) begin
      n_tests++;
      if (ram[i] !== exp_ram[i]) begin
        n_fail++;
        $display("FAIL bp_ram[%0d]: got %h want %h", i, ram[i], exp_ram[i]);
      end
    end
    n_tests++;
    if (wr_count != 128 || done_cnt != 1 || done_bad != 0 || seq_err != 0) begin
      n_fail++;
      $display("FAIL bp_cnt: wr=%0d done=%0d bad=%0d seq=%0d",
               wr_count, done_cnt, done_bad, seq_err);
    end
  endtask

  task automatic test_busy_start();
    cfg_base = 32'h3000; cfg_rs = 8; cfg_cs = 64;
    cfg_fmh = 16; cfg_y0 = 0;
    ready_wait = 1; gap_pct = 20;
    launch();
    repeat (30) @(negedge clk);
    base_addr = 32'h5000;
    fm_h = 2;
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done();
    stray = 1;
    repeat (6) @(negedge clk);
    n_tests++;
    if (wr_count != 128 || done_cnt != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start: wr=%0d done=%0d busy=%b want 128 1 0",
               wr_count, done_cnt, busy);
    end
    n_tests++;
    if (req_q.size() != 32) begin
      n_fail++; $display("FAIL busy_nreq: got %0d want 32", req_q.size());
    end
    for (int i = 0; i < FMI_N_ELEM; i++) begin
      n_tests++;
      if (ram[i] !== exp_ram[i]) begin
        n_fail++;
        $display("FAIL busy_ram[%0d]: got %h want %h", i, ram[i], exp_ram[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    cfg_base = 32'h1000; cfg_rs = 16; cfg_cs = 256;
    cfg_fmh = 16; cfg_y0 = 0;
    ready_wait = 0; gap_pct = 0;
    launch();
    t = 0;
    while (wr_count < 50 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (wr_count < 50) begin
      n_fail++; $display("FAIL rmid_reach: writes=%0d want 50", wr_count);
    end
    #1 rst = 1;
    @(posedge clk);
    #1;
    n_tests++;
    if ({busy, done, mem_req, ram_we} !== 4'b0) begin
      n_fail++;
      $display("FAIL rmid_out: got %b want 0000", {busy, done, mem_req, ram_we});
    end
    @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    n_tests++;
    if (done_cnt != 0) begin
      n_fail++; $display("FAIL rmid_nodone: got %0d want 0", done_cnt);
    end
    launch();
    wait_done();
    n_tests++;
    if (wr_count != 128 || done_cnt != 1 || done_bad != 0 || seq_err != 0) begin
      n_fail++;
      $display("FAIL rmid_cnt: wr=%0d done=%0d bad=%0d seq=%0d",
               wr_count, done_cnt, done_bad, seq_err);
    end
    for (int i = 0; i < FMI_N_ELEM; i++) begin
      n_tests++;
      if (ram[i] !== exp_ram[i]) begin
        n_fail++;
        $display("FAIL rmid_ram[%0d]: got %h want %h", i, ram[i], exp_ram[i]);
      end
    end
  endtask

  task automatic test_wrap();
    cfg_base = 32'hFFFF_FFF8; cfg_rs = 4; cfg_cs = $urandom;
    cfg_fmh = 16; cfg_y0 = 0;
    ready_wait = 0; gap_pct = 10;
    launch();
    wait_done();
    n_tests++;
    if (req_q.size() < 3 || req_q[1] !== 32'hFFFF_FFFC || req_q[2] !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_req: n=%0d want req1=fffffffc req2=00000000",
               req_q.size());
    end
    for (int i = 0; i < exp_req.size() && i < req_q.size(); i++) begin
      n_tests++;
      if (req_q[i] !== exp_req[i]) begin
        n_fail++;
        $display("FAIL wrap_req[%0d]: got %h want %h", i, req_q[i], exp_req[i]);
      end
    end
    for (int i = 0; i < FMI_N_ELEM; i++) begin
      n_tests++;
      if (ram[i] !== exp_ram[i]) begin
        n_fail++;
        $display("FAIL wrap_ram[%0d]: got %h want %h", i, ram[i], exp_ram[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      cfg_base = $urandom; cfg_rs = $urandom_range(1, 64);
      cfg_cs = $urandom;
      cfg_fmh = 10'($urandom_range(1, 12));
      cfg_y0  = 10'($urandom_range(0, 12));
      ready_wait = $urandom_range(0, 2);
      gap_pct    = $urandom_range(0, 50);
      launch();
      wait_done();
      n_tests++;
      if (req_q.size() != exp_req.size() || unstable != 0) begin
        n_fail++;
        $display("FAIL rnd%0d_nreq: got %0d want %0d unstable=%0d",
                 k, req_q.size(), exp_req.size(), unstable);
      end
      for (int i = 0; i < exp_req.size() && i < req_q.size(); i++) begin
        n_tests++;
        if (req_q[i] !== exp_req[i]) begin
          n_fail++;
          $display("FAIL rnd%0d_req[%0d]: got %h want %h",
                   k, i, req_q[i], exp_req[i]);
        end
      end
      for (int i = 0; i < FMI_N_ELEM; i++) begin
        n_tests++;
        if (ram[i] !== exp_ram[i]) begin
          n_fail++;
          $display("FAIL rnd%0d_ram[%0d]: got %h want %h",
                   k, i, ram[i], exp_ram[i]);
        end
      end
      n_tests++;
      if (wr_count != 128 || done_cnt != 1 || done_bad != 0 || seq_err != 0) begin
        n_fail++;
        $display("FAIL rnd%0d_cnt: wr=%0d done=%0d bad=%0d seq=%0d",
                 k, wr_count, done_cnt, done_bad, seq_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_pad();
    test_backpressure();
    test_busy_start();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_fmi_loader.md
Name: dma_fmi_loader

Overview:
Input-side DMA stage that fetches one input feature-map tile (Tix x Tiy x Tif words) from external memory and writes it into the FMI RAM, which the compute array consumes downstream. The tile is fetched row by row as burst reads of Tix words, one burst outstanding at a time. Rows that fall below the bottom edge of the feature map are zero-filled locally, with no memory request issued. Tile geometry and address widths come from dma_pkg (Tix, Tiy, Tif, FMI_N_ELEM, FMI_ADDR_W).

Parameters:
DATA_W, 8, width of one feature-map word
EXT_ADDR_W, 32, external memory word-address width
DIM_W, 10, width of feature-map height and row-index fields

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; launches a tile load when idle
base_addr  in  EXT_ADDR_W  word address of tile element (f=0, y=0, x=0)
row_stride  in  EXT_ADDR_W  word distance between consecutive rows
ch_stride  in  EXT_ADDR_W  word distance between consecutive feature planes
fm_h  in  DIM_W  feature-map height
tile_y0  in  DIM_W  row index of tile row 0 within the feature map
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last RAM write
mem_req  out  1  burst read request valid
mem_ready  in  1  memory accepts the request
mem_addr  out  EXT_ADDR_W  burst start address
mem_len  out  8  burst length; constant Tix
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_W  read data
ram_we  out  1  FMI RAM write enable
ram_addr  out  FMI_ADDR_W  FMI RAM address
ram_wdata  out  DATA_W  FMI RAM write data

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and all counters are 0. Reset mid-operation aborts the load immediately: no done pulse, and an in-flight burst is dropped. Any rvalid arriving after reset while in IDLE is ignored.
- start and all configuration inputs are sampled only in IDLE. start while busy is ignored.
- FSM states: IDLE -> CHK on start. CHK -> REQ if (tile_y0 + y) < fm_h, else PAD. The comparison is done in DIM_W+1 bits.
- REQ: mem_req=1 with mem_addr = row address. mem_addr and mem_req stay stable until mem_ready. The request is accepted in the cycle mem_req & mem_ready, then REQ -> DATA.
- DATA: each mem_rvalid beat is written to the RAM. After Tix beats, go to NEXT. Gaps between beats are allowed. rvalid outside DATA is ignored.
- PAD: writes Tix zero words, one per cycle, then goes to NEXT.
- NEXT: advance the counters.
  - x counts 0..Tix-1.
  - y counts 0..Tiy-1; at wrap, f increments.
  - The row address is kept incrementally: row_addr += row_stride.
  - When a plane completes, plane_addr += ch_stride and row_addr = plane_addr.
  - After f = Tif-1 and y = Tiy-1, go to DONE; otherwise go to CHK.
- DONE: done=1 for one cycle, busy drops in the same cycle, then go to IDLE.
- All address arithmetic wraps modulo 2^EXT_ADDR_W.
- Write path: ram_we, ram_addr and ram_wdata are registered, one cycle after the rvalid beat or PAD cycle.
  - ram_addr = f*Tix*Tiy + y*Tix + x. It is implemented as a sequential counter 0..FMI_N_ELEM-1 and never wraps within a tile.
  - Exactly FMI_N_ELEM writes occur per tile.
- Throughput: at most one write per cycle. Row-to-row overhead is 2 cycles (NEXT, CHK) plus the request handshake.
- done is asserted the cycle after the final write is presented, so the RAM holds the complete tile when done is seen.

Test Plan:
- Full in-bounds tile: base=0x1000, row_stride=16, ch_stride=256, fm_h=16, tile_y0=0, zero-wait memory returning data = low 8 bits of the address -> 32 requests, at 0x1000, 0x1010, 0x1020, 0x1030, 0x1100, ...; 128 writes to addresses 0..127; done once; RAM[5] = 0x11.
- Bottom padding: fm_h=6, tile_y0=4 -> rows y=0,1 fetched and y=2,3 zero-filled in every plane; 16 requests total; RAM[8..15] = 0 for f=0.
- Backpressure: mem_ready low 3 cycles per request, rvalid with random gaps -> mem_addr stable while mem_req is high; same RAM contents as the first test; exactly one request accepted per in-bounds row.
- start while busy plus a stray rvalid in IDLE -> the second start is ignored, the stray beat produces no RAM write, and the write count stays 128.
- Reset mid-tile after 50 writes -> outputs 0 on the next cycle and no done. A fresh start then completes a full 128-write load, with done after the final write.
- Address wrap: base=0xFFFFFFF8, row_stride=4 -> the second row request is at 0xFFFFFFFC and the third at 0x00000000.
